// File: rtl/muldiv_pkg.sv
// Shared types and decode helpers for the RV32M execution controller.
package muldiv_pkg;

   localparam int unsigned MD_OP_W = 3;

   // Encoding follows the RISC-V M-extension funct3 field.
   typedef enum logic [MD_OP_W-1:0] {
      OpMul    = 3'b000,
      OpMulh   = 3'b001,
      OpMulhsu = 3'b010,
      OpMulhu  = 3'b011,
      OpDiv    = 3'b100,
      OpDivu   = 3'b101,
      OpRem    = 3'b110,
      OpRemu   = 3'b111
   } md_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StBusy,
      StDone
   } ctrl_state_e;

   function automatic logic is_mul(md_op_e op);
      return ~op[2];
   endfunction

   function automatic logic is_signed_div(md_op_e op);
      return (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/MUL_DIV.sv
// Iterative shift-add multiplier / restoring divider; SIZE iterations per op.
// Division works on unsigned magnitudes: quotient in the low half, remainder in the high half.
module MUL_DIV #(
   parameter int unsigned SIZE = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              flush,
   input  logic              mul_div,
   input  logic              num1_signed,
   input  logic              num2_signed,
   input  logic [SIZE-1:0]   num1,
   input  logic [SIZE-1:0]   num2,
   output logic [2*SIZE-1:0] result,
   output logic              ready
);

   localparam int unsigned CntW = $clog2(SIZE);

   logic                busy_q, mode_q, neg_q, ready_q;
   logic [CntW-1:0]     cnt_q;
   logic [SIZE-1:0]     opb_q, a_mag, b_mag;
   logic [2*SIZE-1:0]   p_q, p_mul, p_div;
   logic [SIZE:0]       mul_sum, rem_sh, diff;
   logic                a_neg, b_neg;

   always_comb begin
      a_neg   = num1_signed & num1[SIZE-1];
      b_neg   = num2_signed & num2[SIZE-1];
      a_mag   = a_neg ? -num1 : num1;
      b_mag   = b_neg ? -num2 : num2;
      mul_sum = {1'b0, p_q[2*SIZE-1:SIZE]} + (p_q[0] ? {1'b0, opb_q} : '0);
      p_mul   = {mul_sum, p_q[SIZE-1:1]};
      // Shifted partial remainder needs one extra bit before the trial subtract.
      rem_sh  = p_q[2*SIZE-1:SIZE-1];
      diff    = rem_sh - {1'b0, opb_q};
      p_div   = diff[SIZE] ? {rem_sh[SIZE-1:0], p_q[SIZE-2:0], 1'b0}
                           : {diff[SIZE-1:0], p_q[SIZE-2:0], 1'b1};
      result  = neg_q ? -p_q : p_q;
      ready   = ready_q;
   end

   always_ff @(posedge clk) begin
      if (!rstn || flush) begin
         busy_q  <= 1'b0;
         mode_q  <= 1'b0;
         neg_q   <= 1'b0;
         ready_q <= 1'b0;
         cnt_q   <= '0;
         opb_q   <= '0;
         p_q     <= '0;
      end else begin
         ready_q <= 1'b0;
         if (start) begin
            busy_q <= 1'b1;
            mode_q <= mul_div;
            neg_q  <= mul_div & (a_neg ^ b_neg);
            cnt_q  <= '0;
            opb_q  <= b_mag;
            p_q    <= {{SIZE{1'b0}}, a_mag};
         end else if (busy_q) begin
            p_q   <= mode_q ? p_mul : p_div;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(SIZE - 1)) begin
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/muldiv_exec_ctrl.sv
// RV32M execution controller: decodes funct3, sequences MUL_DIV, applies sign fixups,
// short-circuits divide-by-zero and signed overflow, and presents a tagged CDB result.
module muldiv_exec_ctrl
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned TAG_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MD_OP_W-1:0] in_funct3,
   input  logic [XLEN-1:0]    in_rs1,
   input  logic [XLEN-1:0]    in_rs2,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [XLEN-1:0]    out_data,
   output logic [TAG_W-1:0]   out_tag
);

   localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

   ctrl_state_e       state_q;
   md_op_e            op_in, op_q;
   logic [XLEN-1:0]   num1_q, num2_q, rs1_mag, rs2_mag, special_res, fixed_res, md_lo, md_hi;
   logic [XLEN-1:0]   out_data_q;
   logic [TAG_W-1:0]  tag_q, out_tag_q;
   logic              num1_signed_q, num2_signed_q, mul_div_q, qneg_q, rneg_q;
   logic              md_start_q, out_valid_q;
   logic              rs1_neg, rs2_neg, sdiv_in, div_zero, div_ovf, is_special;
   logic              num1_signed_in, num2_signed_in;
   logic              md_ready, md_flush, md_rstn;
   logic [2*XLEN-1:0] md_result;

   always_comb begin
      op_in          = md_op_e'(in_funct3);
      rs1_neg        = in_rs1[XLEN-1];
      rs2_neg        = in_rs2[XLEN-1];
      sdiv_in        = is_signed_div(op_in);
      div_zero       = !is_mul(op_in) && (in_rs2 == '0);
      div_ovf        = sdiv_in && (in_rs1 == MinInt) && (in_rs2 == '1);
      is_special     = div_zero || div_ovf;
      rs1_mag        = (sdiv_in && rs1_neg) ? -in_rs1 : in_rs1;
      rs2_mag        = (sdiv_in && rs2_neg) ? -in_rs2 : in_rs2;
      num1_signed_in = (op_in == OpMul) || (op_in == OpMulh) || (op_in == OpMulhsu);
      num2_signed_in = (op_in == OpMul) || (op_in == OpMulh);
      // funct3[1] separates REM/REMU from DIV/DIVU.
      if (div_zero) begin
         special_res = op_in[1] ? in_rs1 : '1;
      end else begin
         special_res = op_in[1] ? '0 : in_rs1;
      end
   end

   always_comb begin
      md_lo = md_result[XLEN-1:0];
      md_hi = md_result[2*XLEN-1:XLEN];
      case (op_q)
         OpMul:                     fixed_res = md_lo;
         OpMulh, OpMulhsu, OpMulhu: fixed_res = md_hi;
         OpDiv:                     fixed_res = qneg_q ? -md_lo : md_lo;
         OpDivu:                    fixed_res = md_lo;
         OpRem:                     fixed_res = rneg_q ? -md_hi : md_hi;
         OpRemu:                    fixed_res = md_hi;
         default:                   fixed_res = md_lo;
      endcase
   end

   assign in_ready  = (state_q == StIdle) && !flush;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign md_flush  = rst | flush;
   assign md_rstn   = ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         op_q          <= OpMul;
         tag_q         <= '0;
         num1_q        <= '0;
         num2_q        <= '0;
         num1_signed_q <= 1'b0;
         num2_signed_q <= 1'b0;
         mul_div_q     <= 1'b0;
         qneg_q        <= 1'b0;
         rneg_q        <= 1'b0;
         md_start_q    <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_tag_q     <= '0;
      end else if (flush) begin
         state_q     <= StIdle;
         md_start_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  op_q  <= op_in;
                  tag_q <= in_tag;
                  if (is_special) begin
                     out_data_q  <= special_res;
                     out_tag_q   <= in_tag;
                     out_valid_q <= 1'b1;
                     state_q     <= StDone;
                  end else begin
                     num1_q        <= rs1_mag;
                     num2_q        <= rs2_mag;
                     num1_signed_q <= num1_signed_in;
                     num2_signed_q <= num2_signed_in;
                     mul_div_q     <= is_mul(op_in);
                     qneg_q        <= sdiv_in & (rs1_neg ^ rs2_neg);
                     rneg_q        <= sdiv_in & rs1_neg;
                     md_start_q    <= 1'b1;
                     state_q       <= StLaunch;
                  end
               end
            end
            StLaunch: begin
               md_start_q <= 1'b0;
               state_q    <= StBusy;
            end
            StBusy: begin
               if (md_ready) begin
                  out_data_q  <= fixed_res;
                  out_tag_q   <= tag_q;
                  out_valid_q <= 1'b1;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   MUL_DIV #(
      .SIZE(XLEN)
   ) u_mul_div (
      .clk         (clk),
      .rstn        (md_rstn),
      .start       (md_start_q),
      .flush       (md_flush),
      .mul_div     (mul_div_q),
      .num1_signed (num1_signed_q),
      .num2_signed (num2_signed_q),
      .num1        (num1_q),
      .num2        (num2_q),
      .result      (md_result),
      .ready       (md_ready)
   );

endmodule
